uart_control_receiver: RTL

UART_CONTROL_RECEIVER -- requirements
Module: uart_control_receiver

---
 rtl/uart_control_receiver.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_control_receiver.sv
// uart_control_receiver
// Oversampled UART receive controller. It synchronizes the RX line, finds the
// start bit and samples each bit at its centre. It then pushes the assembled
// word into an external RX FIFO, or flags a framing or overrun error.
// It also turns host pop requests into FIFO read strobes.
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit. That build also adds the
// error_parity output.
module uart_control_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 serial_data_in,
  input  logic                 full,
  input  logic                 empty,
  input  logic                 read_data,
  output logic                 write,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 read,
  output logic                 busy,
  output logic                 error_framing,
  output logic                 error_overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 error_parity,
`endif
  output logic                 error_read_data
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  // Sample-counter values at which the start bit is re-checked at mid-bit,
  // and at which data/parity/stop bits are taken.
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    ,
    PARITY = 3'd4
`endif
  } state_t;

  state_t                 state_reg, state_next;
  logic [SW-1:0]          sample_count_reg, sample_count_next;
  logic [BW-1:0]          bit_count_reg, bit_count_next;
  logic [DATA_BITS-1:0]   rx_data_reg, rx_data_next;
  logic                   break_reg, break_next;
  logic [1:0]             sync_reg;
  logic                   rx_s;
  logic                   sample_last;
  logic                   parity_bad;

`ifdef UART_RX_PARITY_EN
  logic                   parity_bit_reg, parity_bit_next;
  logic                   parity_err;
`endif

  // Two-flop synchronizer for the asynchronous RX line. It resets to the idle
  // (high) level so that no false start bit is seen after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], serial_data_in};
    end
  end

  assign rx_s        = sync_reg[1];
  assign sample_last = (sample_count_reg == FULL_LAST);

`ifdef UART_RX_PARITY_EN
  // Even parity: the data bits XORed with the received parity bit must be 0.
  assign parity_bad = ^{rx_data_reg, parity_bit_reg};
`else
  assign parity_bad = 1'b0;
`endif

  // State register plus frame counters, shift register and break-hold flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      sample_count_reg <= '0;
      bit_count_reg    <= '0;
      rx_data_reg      <= '0;
      break_reg        <= 1'b0;
    end else begin
      state_reg        <= state_next;
      sample_count_reg <= sample_count_next;
      bit_count_reg    <= bit_count_next;
      rx_data_reg      <= rx_data_next;
      break_reg        <= break_next;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Holds the received parity bit until the stop-bit decision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_bit_reg <= 1'b0;
    end else begin
      parity_bit_reg <= parity_bit_next;
    end
  end
`endif

  // Next-state logic and the single-cycle frame-result strobes.
  always_comb begin
    state_next        = state_reg;
    sample_count_next = sample_count_reg;
    bit_count_next    = bit_count_reg;
    rx_data_next      = rx_data_reg;
    // A break keeps the receiver parked until the line is seen high again.
    break_next        = break_reg & ~rx_s;
    write             = 1'b0;
    error_framing     = 1'b0;
    error_overrun     = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bit_next   = parity_bit_reg;
    parity_err        = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        if (baud_tick && !rx_s && !break_reg) begin
          state_next        = START;
          sample_count_next = '0;
        end
      end

      START: begin
        if (baud_tick) begin
          if (sample_count_reg == HALF_LAST) begin
            sample_count_next = '0;
            if (!rx_s) begin
              // Still low at mid start bit: this is a real frame.
              state_next     = DATA;
              bit_count_next = '0;
            end else begin
              // Line went back high: treat as a glitch and drop it silently.
              state_next = IDLE;
            end
          end else begin
            sample_count_next = sample_count_reg + 1'b1;
          end
        end
      end

      DATA: begin
        if (baud_tick) begin
          if (sample_last) begin
            sample_count_next = '0;
            // LSB arrives first, so shift in from the MSB side.
            rx_data_next      = {rx_s, rx_data_reg[DATA_BITS-1:1]};
            if (bit_count_reg == BIT_LAST) begin
              bit_count_next = '0;
`ifdef UART_RX_PARITY_EN
              state_next     = PARITY;
`else
              state_next     = STOP;
`endif
            end else begin
              bit_count_next = bit_count_reg + 1'b1;
            end
          end else begin
            sample_count_next = sample_count_reg + 1'b1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          if (sample_last) begin
            sample_count_next = '0;
            parity_bit_next   = rx_s;
            state_next        = STOP;
          end else begin
            sample_count_next = sample_count_reg + 1'b1;
          end
        end
      end
`endif

      STOP: begin
        if (baud_tick) begin
          if (sample_last) begin
            sample_count_next = '0;
            state_next        = IDLE;
            if (!rx_s) begin
              // Missing stop bit. If the line stays low (break), do not
              // re-arm until it has returned high.
              error_framing = 1'b1;
              break_next    = 1'b1;
            end else if (parity_bad) begin
`ifdef UART_RX_PARITY_EN
              parity_err = 1'b1;
`endif
            end else if (full) begin
              error_overrun = 1'b1;
            end else begin
              write = 1'b1;
            end
          end else begin
            sample_count_next = sample_count_reg + 1'b1;
          end
        end
      end

      default: begin
        state_next        = IDLE;
        sample_count_next = '0;
        bit_count_next    = '0;
      end
    endcase
  end

`ifdef UART_RX_PARITY_EN
  assign error_parity = parity_err;
`endif

  assign rx_data         = rx_data_reg;
  assign busy            = (state_reg != IDLE);
  assign read            = read_data & ~empty;
  assign error_read_data = read_data & empty;

endmodule
